// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop process
// one operand bit per clock, LSB first, under a start/busy/done handshake.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sum_bit;
   logic             carry_nxt;

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = done_q;

      sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

      case (state_q)
         IDLE: begin
            // Subtract is a + ~b + 1: the +1 enters through the carry flop.
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = mode ? ~b : b;
               carry_d = mode;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            res_d   = {sum_bit, res_q[WIDTH-1:1]};
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CW'(1);
            // On the MSB, carry_q is the carry into it and carry_nxt the carry out.
            if (cnt_q == LAST) begin
               s_d     = {sum_bit, res_q[WIDTH-1:1]};
               cout_d  = carry_nxt;
               ovf_d   = carry_q ^ carry_nxt;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
